// File: rtl/oled_i2c_pkg.sv
// Shared types and constants for the OLED-side I2C responder.
// State encoding, SSD1306 control-byte bit positions and the default chip address.
package oled_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_CTRL,
    ST_CTRL_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } state_e;

  localparam int         CO_BIT            = 7;
  localparam int         DC_BIT            = 6;
  localparam logic [6:0] DEFAULT_CHIP_ADDR = 7'h3C;
  localparam logic [3:0] LAST_BIT_IDX      = 4'd7;

  function automatic logic is_byte_state(state_e s);
    return (s == ST_ADDR) || (s == ST_CTRL) || (s == ST_DATA);
  endfunction

  function automatic logic is_ack_state(state_e s);
    return (s == ST_ADDR_ACK) || (s == ST_CTRL_ACK) || (s == ST_DATA_ACK);
  endfunction

  // Co=1 means another control byte follows; Co=0 streams payload bytes.
  function automatic state_e ack_next(state_e s, logic co);
    case (s)
      ST_ADDR_ACK: return ST_CTRL;
      ST_CTRL_ACK: return ST_DATA;
      default:     return co ? ST_CTRL : ST_DATA;
    endcase
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers plus history registers for SCL/SDA; emits registered
// single-cycle edge, START and STOP events with the matching sampled SDA level.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_sync,
  output logic start_det,
  output logic stop_det
);

  logic scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d, scl_hist_q, scl_hist_d;
  logic sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d, sda_hist_q, sda_hist_d;
  logic rise_q, rise_d, fall_q, fall_d, start_q, start_d, stop_q, stop_d;
  logic sda_smp_q, sda_smp_d;
  logic start_now, stop_now;

  always_comb begin
    scl_meta_d = scl_in;
    scl_sync_d = scl_meta_q;
    scl_hist_d = scl_sync_q;
    sda_meta_d = sda_in;
    sda_sync_d = sda_meta_q;
    sda_hist_d = sda_sync_q;
    start_now  = scl_sync_q & scl_hist_q & ~sda_sync_q &  sda_hist_q;
    stop_now   = scl_sync_q & scl_hist_q &  sda_sync_q & ~sda_hist_q;
    // SCL edges are suppressed in a cycle that carries a START or STOP.
    rise_d     =  scl_sync_q & ~scl_hist_q & ~start_now & ~stop_now;
    fall_d     = ~scl_sync_q &  scl_hist_q & ~start_now & ~stop_now;
    start_d    = start_now;
    stop_d     = stop_now;
    sda_smp_d  = sda_sync_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_smp_q  <= 1'b1;
    end else begin
      scl_meta_q <= scl_meta_d;
      scl_sync_q <= scl_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_meta_q <= sda_meta_d;
      sda_sync_q <= sda_sync_d;
      sda_hist_q <= sda_hist_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      sda_smp_q  <= sda_smp_d;
    end
  end

  assign scl_rise  = rise_q;
  assign scl_fall  = fall_q;
  assign sda_sync  = sda_smp_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;

endmodule

// File: rtl/oled_i2c_responder.sv
// I2C write-only target emulating the SSD1306 bus side: address match, ACK
// driving and control-byte (Co/DC) decoding into a per-byte valid strobe.
module oled_i2c_responder
  import oled_i2c_pkg::*;
#(
  parameter logic [6:0] OLED_CHIP_ADDR = DEFAULT_CHIP_ADDR,
  parameter int         MIN_PHASE      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oen,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_error,
  output logic       busy
);

  // Sync, history and edge registers give 4 clk from pad edge to SDA drive.
  if (MIN_PHASE < 4) begin : g_phase_guard
    $error("MIN_PHASE must cover the 4-cycle pad-to-drive latency");
  end

  logic scl_rise, scl_fall, sda_sync, start_det, stop_det;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_sync  (sda_sync),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       co_q, co_d, dc_q, dc_d;
  logic       sda_oen_q, sda_oen_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_is_data_q, byte_is_data_d;
  logic       frame_start_q, frame_start_d;
  logic       frame_end_q, frame_end_d;
  logic       frame_error_q, frame_error_d;

  logic [7:0] shift_nxt;
  logic       byte_done;
  logic       in_frame;
  logic       mid_byte;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    co_d           = co_q;
    dc_d           = dc_q;
    sda_oen_d      = sda_oen_q;
    byte_valid_d   = 1'b0;
    byte_data_d    = byte_data_q;
    byte_is_data_d = byte_is_data_q;
    frame_start_d  = 1'b0;
    frame_end_d    = 1'b0;
    frame_error_d  = 1'b0;

    shift_nxt = {shift_q[6:0], sda_sync};
    byte_done = scl_rise && (bit_cnt_q == LAST_BIT_IDX);
    in_frame  = (state_q != ST_IDLE) && (state_q != ST_IGNORE);
    mid_byte  = is_byte_state(state_q) && (bit_cnt_q != 4'd0) && (bit_cnt_q <= LAST_BIT_IDX);

    if (start_det || stop_det) begin
      frame_end_d   = in_frame;
      frame_error_d = mid_byte;
      sda_oen_d     = 1'b0;
      bit_cnt_d     = 4'd0;
      state_d       = start_det ? ST_ADDR : ST_IDLE;
    end else begin
      if (is_byte_state(state_q) && scl_rise) begin
        shift_d   = shift_nxt;
        bit_cnt_d = bit_cnt_q + 4'd1;
      end

      case (state_q)
        ST_ADDR: begin
          if (byte_done) begin
            if ((shift_nxt[7:1] == OLED_CHIP_ADDR) && !shift_nxt[0]) begin
              state_d       = ST_ADDR_ACK;
              frame_start_d = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_CTRL: begin
          if (byte_done) begin
            co_d    = shift_nxt[CO_BIT];
            dc_d    = shift_nxt[DC_BIT];
            state_d = ST_CTRL_ACK;
          end
        end
        ST_DATA: begin
          if (byte_done) begin
            byte_valid_d   = 1'b1;
            byte_data_d    = shift_nxt;
            byte_is_data_d = dc_q;
            state_d        = ST_DATA_ACK;
          end
        end
        default: begin
          // First SCL fall after the 8th bit opens the ACK slot, the next closes it.
          if (is_ack_state(state_q) && scl_fall) begin
            if (!sda_oen_q) begin
              sda_oen_d = 1'b1;
            end else begin
              sda_oen_d = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ack_next(state_q, co_q);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= 4'd0;
      co_q           <= 1'b0;
      dc_q           <= 1'b0;
      sda_oen_q      <= 1'b0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= 8'h00;
      byte_is_data_q <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      co_q           <= co_d;
      dc_q           <= dc_d;
      sda_oen_q      <= sda_oen_d;
      byte_valid_q   <= byte_valid_d;
      byte_data_q    <= byte_data_d;
      byte_is_data_q <= byte_is_data_d;
      frame_start_q  <= frame_start_d;
      frame_end_q    <= frame_end_d;
      frame_error_q  <= frame_error_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign sda_out      = 1'b0;
  assign sda_oen      = sda_oen_q;
  assign byte_valid   = byte_valid_q;
  assign byte_data    = byte_data_q;
  assign byte_is_data = byte_is_data_q;
  assign frame_start  = frame_start_q;
  assign frame_end    = frame_end_q;
  assign frame_error  = frame_error_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_oled_i2c_responder.sv
// Directed bench: bit-banged I2C master on an open-drain SDA model, with
// event counters and a byte log compared against hand-computed expectations.
module tb_oled_i2c_responder;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       scl_in;
  logic       sda_in;
  logic       sda_out;
  logic       sda_oen;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_is_data;
  logic       frame_start;
  logic       frame_end;
  logic       frame_error;
  logic       busy;

  assign scl_in = m_scl;
  assign sda_in = m_sda & ~sda_oen;

  oled_i2c_responder dut (
    .clk          (clk),
    .reset        (reset),
    .scl_in       (scl_in),
    .sda_in       (sda_in),
    .sda_out      (sda_out),
    .sda_oen      (sda_oen),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_fs, n_fe, n_err;
  logic       oen_seen;
  logic [8:0] bq[$];

  always @(negedge clk) begin
    if (byte_valid)  bq.push_back({byte_is_data, byte_data});
    if (frame_start) n_fs++;
    if (frame_end)   n_fe++;
    if (frame_error) n_err++;
    if (sda_oen)     oen_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input logic [8:0] exp[$]);
    logic [8:0] got;
    check_eq({tag, "_count"}, bq.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < bq.size()) ? bq[i] : 9'h1FF;
      check_eq($sformatf("%s_byte%0d", tag, i), got, exp[i]);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    @(posedge clk);
    n_fs = 0; n_fe = 0; n_err = 0; oen_seen = 1'b0;
    bq.delete();
  endtask

  task automatic i2c_start();
    if (m_scl == 1'b0) begin
      m_sda = 1'b1; wait_clk(Q);
      m_scl = 1'b1; wait_clk(Q);
    end
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wait_clk(Q);
    m_scl = 1'b1; wait_clk(2 * Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    acked = (sda_in == 1'b0);
    wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic write_seq(input logic [7:0] bytes[$], output int n_ack);
    logic a;
    n_ack = 0;
    foreach (bytes[i]) begin
      write_byte(bytes[i], a);
      if (a) n_ack++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   acks;
    logic a;
    logic [7:0] v;

    n_fs = 0; n_fe = 0; n_err = 0; oen_seen = 1'b0;
    wait_clk(5);
    check_eq("rst_oen",   sda_oen, 0);
    check_eq("rst_out",   sda_out, 0);
    check_eq("rst_busy",  busy, 0);
    check_eq("rst_valid", byte_valid, 0);
    check_eq("rst_data",  byte_data, 0);
    check_eq("rst_isdat", byte_is_data, 0);
    check_eq("rst_pulses", {frame_start, frame_end, frame_error}, 0);
    reset = 1'b0;
    wait_clk(5);

    // Command stream: Co=0, DC=0
    clear_mon();
    i2c_start();
    write_seq('{8'h78, 8'h00, 8'hAE, 8'hD5, 8'h80}, acks);
    check_eq("t1_busy_mid", busy, 1);
    i2c_stop();
    wait_clk(4);
    check_eq("t1_acks", acks, 5);
    check_eq("t1_fstart", n_fs, 1);
    check_eq("t1_fend", n_fe, 1);
    check_bytes("t1", '{9'h0AE, 9'h0D5, 9'h080});
    check_eq("t1_busy_end", busy, 0);
    check_eq("t1_hold_data", byte_data, 8'h80);

    // Foreign address: never drive SDA
    clear_mon();
    i2c_start();
    write_seq('{8'h7A, 8'h00, 8'hAE, 8'h40, 8'h12}, acks);
    check_eq("t2_busy_ign", busy, 1);
    i2c_stop();
    wait_clk(4);
    check_eq("t2_acks", acks, 0);
    check_eq("t2_oen_seen", oen_seen, 0);
    check_eq("t2_fstart", n_fs, 0);
    check_eq("t2_fend", n_fe, 0);
    check_bytes("t2", '{});
    check_eq("t2_busy_end", busy, 0);

    // Read request is NACKed and ignored
    clear_mon();
    i2c_start();
    write_byte(8'h79, a);
    wait_clk(2);
    check_eq("t3_ack", a, 0);
    check_eq("t3_busy_ign", busy, 1);
    check_eq("t3_fstart", n_fs, 0);
    check_eq("t3_oen_seen", oen_seen, 0);
    i2c_stop();
    wait_clk(4);
    check_eq("t3_busy_end", busy, 0);

    // Co=1 command then Co=1 data control byte
    clear_mon();
    i2c_start();
    write_seq('{8'h78, 8'h80, 8'hAF, 8'hC0, 8'h55}, acks);
    i2c_stop();
    wait_clk(4);
    check_eq("t4_acks", acks, 5);
    check_eq("t4_fstart", n_fs, 1);
    check_bytes("t4", '{9'h0AF, 9'h155});
    check_eq("t4_isdata_hold", byte_is_data, 1);

    // STOP inside a data byte
    clear_mon();
    i2c_start();
    write_seq('{8'h78, 8'h40}, acks);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    i2c_stop();
    wait_clk(4);
    check_eq("t5_acks", acks, 2);
    check_eq("t5_ferr", n_err, 1);
    check_eq("t5_fend", n_fe, 1);
    check_bytes("t5", '{});
    check_eq("t5_busy", busy, 0);

    // Repeated START while in the data-byte ACK phase, then a new frame
    clear_mon();
    i2c_start();
    write_seq('{8'h78, 8'h00}, acks);
    v = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    m_sda = v[0]; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
    check_eq("t6_fend_rs", n_fe, 1);
    check_eq("t6_ferr_rs", n_err, 0);
    check_eq("t6_busy_rs", busy, 1);
    write_seq('{8'h78, 8'h00, 8'hAF}, acks);
    i2c_stop();
    wait_clk(4);
    check_eq("t6_acks2", acks, 3);
    check_eq("t6_fstart", n_fs, 2);
    check_eq("t6_fend", n_fe, 2);
    check_bytes("t6", '{9'h0A5, 9'h0AF});

    // Reset during an ACK slot releases SDA on the next cycle
    clear_mon();
    i2c_start();
    v = 8'h78;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    for (int i = 0; i < 20 && !sda_oen; i++) wait_clk(1);
    check_eq("t7_oen_pre", sda_oen, 1);
    reset = 1'b1;
    wait_clk(1);
    check_eq("t7_oen_rst", sda_oen, 0);
    check_eq("t7_busy_rst", busy, 0);
    m_sda = 1'b1; m_scl = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(6);
    check_eq("t7_busy_idle", busy, 0);
    i2c_start();
    write_seq('{8'h78}, acks);
    check_eq("t7_ack_new", acks, 1);
    check_eq("t7_fstart_new", n_fs, 2);
    i2c_stop();
    wait_clk(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
